systolic_mac_array: RTL and testbench
=====================================

Name: systolic_mac_array

Overview:
Parametrised ROWS x COLS output-stationary systolic grid of MAC processing elements. It computes C = A x B over a streamed inner dimension K. It adds what a single MAC cell lacks: internal input skewing, valid/ready input and output handshakes, tile-end flush sequencing, and row-by-row accumulator drain. It sits between the operand buffers and the result writeback path of the vector processing unit.

Parameters:
ROWS, 4, number of PE rows (A rows / C rows), >=1
COLS, 4, number of PE columns (B columns / C columns), >=1
DATA_WIDTH, 8, operand width
ACC_WIDTH, 32, accumulator width, >= 2*DATA_WIDTH
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  array accepts a beat
in_last  in  1  qualifies the final beat of a tile; sampled only on handshake
a_in  in  ROWS*DATA_WIDTH  column k of A; element r at [r*DATA_WIDTH +: DATA_WIDTH]
b_in  in  COLS*DATA_WIDTH  row k of B; element c at [c*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts the result row
out_data  out  COLS*ACC_WIDTH  C row out_row; column c at [c*ACC_WIDTH +: ACC_WIDTH]
out_row  out  max(1,$clog2(ROWS))  index of the row being presented
busy  out  1  high whenever state != LOAD

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=LOAD, all accumulators, skew registers and PE pass-through registers = 0, out_valid=0, out_row=0, in_ready=1, busy=0. This holds on reset asserted in any state, including mid-FLUSH or mid-DRAIN. No residue may survive into the next tile.
- Skew: row r operand passes through r skew registers, then feeds PE(r,0). Column c operand passes through c skew registers, then feeds PE(0,c).
- PE pass-through: each PE forwards a right and b down through one register stage.
- MAC alignment: a beat accepted in cycle T is accumulated in PE(r,c) at the clock edge ending cycle T+r+c.
- Advance: skew and PE registers advance every cycle in LOAD and FLUSH. In a cycle with no handshake, zeros are injected at both edges. Gaps in in_valid therefore do not change results.
- MAC arithmetic: product is DATA_WIDTH x DATA_WIDTH, signed or unsigned per SIGNED. It is sign- or zero-extended to ACC_WIDTH and added with wrap-around modulo 2^ACC_WIDTH. There is no saturation.
- State LOAD: in_ready=1, out_valid=0. On a handshake with in_last=1, go to FLUSH, or directly to DRAIN when ROWS+COLS-2 == 0.
- State FLUSH: in_ready=0. Lasts exactly ROWS+COLS-2 cycles, counted by a down-counter. Zeros are injected. Then go to DRAIN.
- State DRAIN: in_ready=0 and out_valid=1. out_data = accumulators of row out_row, with out_row starting at 0.
  - On out_valid&out_ready, out_row increments.
  - When row ROWS-1 is accepted: clear all accumulators and skew/PE registers, set out_row=0, return to LOAD. in_ready=1 on the following cycle.
- Output hold: while out_ready=0, out_data and out_row are held stable.
- Boundaries:
  - in_last without in_valid is ignored.
  - in_valid while in_ready=0 is not consumed.
  - K>=1 always, since in_last rides a beat.
  - Back-to-back tiles carry no accumulator carry-over.

Test Plan:
1. Basic 2x2 tile. Setup: ROWS=COLS=2, SIGNED=1.
   - Stimulus: beat0 a={1,3}, b={5,6}; beat1 a={2,4}, b={7,8}, in_last, accepted in cycle TL.
   - Required: FLUSH covers TL+1..TL+2; out_valid rises at TL+3. Row0 = {19,22}, row1 = {43,50}. in_ready returns 1 one cycle after row1 is accepted.
2. Input gaps. Same data as scenario 1 with in_valid low for 3 cycles between beats -> identical C, in_ready stays 1 through the gap.
3. Sign handling. 2x2, single beat with in_last, every element 0x80.
   - SIGNED=1 -> all four results 16384.
   - SIGNED=0, all elements 0xFF -> all four results 65025.
4. Wrap-around. ACC_WIDTH=16, SIGNED=0, 2x2, two beats of all 0xFF -> every result 64514 (130050 mod 65536).
5. Output backpressure. Run scenario 1 with out_ready low for 5 cycles at the start of DRAIN -> out_valid=1 and out_row=0 with out_data={19,22} held stable, in_ready=0. Then both rows drain correctly.
6. Reset mid-operation. Assert rst for 1 cycle during FLUSH -> next cycle out_valid=0, in_ready=1, busy=0. Then run scenario 1 -> exactly {19,22},{43,50}, with no contribution from the aborted tile.

Source files
------------

// File: rtl/systolic_mac_array.sv
// Output-stationary ROWS x COLS systolic MAC grid computing C = A x B over a streamed K.
// Handshake: a beat/row transfers on a clock edge where valid && ready; an unaccepted beat is never consumed.
module systolic_mac_array #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   in_last,
  input  logic [ROWS*DATA_WIDTH-1:0]             a_in,
  input  logic [COLS*DATA_WIDTH-1:0]             b_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [COLS*ACC_WIDTH-1:0]              out_data,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0]   out_row,
  output logic                                   busy
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL = ROWS + COLS - 2;
  localparam int CW = $clog2(ROWS + COLS);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          hs;
  logic          adv;
  logic          clr;
  logic          last_row;

  logic [DW-1:0]        a_inj  [ROWS];
  logic [DW-1:0]        a_edge [ROWS];
  logic [DW-1:0]        b_inj  [COLS];
  logic [DW-1:0]        b_edge [COLS];
  logic [DW-1:0]        a_pin  [ROWS][COLS];
  logic [DW-1:0]        b_pin  [ROWS][COLS];
  logic [DW-1:0]        a_q    [ROWS][COLS];
  logic [DW-1:0]        b_q    [ROWS][COLS];
  logic [ACC_WIDTH-1:0] acc    [ROWS][COLS];

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
  assign hs        = in_valid && in_ready;
  assign adv       = (state == LOAD) || (state == FLUSH);
  assign last_row  = (out_row == RW'(ROWS - 1));
  // Accepting the final row wipes the whole datapath so nothing leaks into the next tile.
  assign clr       = (state == DRAIN) && out_ready && last_row;

  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] ps;
    logic        [2*DW-1:0] pu;
    ps = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    pu = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    if (SIGNED != 0) mul_ext = ACC_WIDTH'(ps);
    else             mul_ext = ACC_WIDTH'(pu);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      out_row <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (hs && in_last) begin
            if (FL == 0) begin
              state <= DRAIN;
            end else begin
              state <= FLUSH;
              cnt   <= CW'(FL - 1);
            end
          end
        end
        FLUSH: begin
          if (cnt == '0) state <= DRAIN;
          else           cnt   <= cnt - 1'b1;
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_row) begin
              state   <= LOAD;
              out_row <= '0;
            end else begin
              out_row <= out_row + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Idle cycles inject zeros so gaps in the beat stream contribute nothing.
  always_comb begin
    for (int r = 0; r < ROWS; r++) a_inj[r] = hs ? a_in[r*DW +: DW] : '0;
    for (int c = 0; c < COLS; c++) b_inj[c] = hs ? b_in[c*DW +: DW] : '0;
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
    if (gr == 0) begin : g_direct
      assign a_edge[gr] = a_inj[gr];
    end else begin : g_regs
      logic [DW-1:0] sk [gr];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int j = 0; j < gr; j++) sk[j] <= '0;
        end else if (adv) begin
          sk[0] <= a_inj[gr];
          for (int j = 1; j < gr; j++) sk[j] <= sk[j-1];
        end
      end
      assign a_edge[gr] = sk[gr-1];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_bskew
    if (gc == 0) begin : g_direct
      assign b_edge[gc] = b_inj[gc];
    end else begin : g_regs
      logic [DW-1:0] sk [gc];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int j = 0; j < gc; j++) sk[j] <= '0;
        end else if (adv) begin
          sk[0] <= b_inj[gc];
          for (int j = 1; j < gc; j++) sk[j] <= sk[j-1];
        end
      end
      assign b_edge[gc] = sk[gc-1];
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      a_pin[r][0] = a_edge[r];
      for (int c = 1; c < COLS; c++) a_pin[r][c] = a_q[r][c-1];
    end
    for (int c = 0; c < COLS; c++) begin
      b_pin[0][c] = b_edge[c];
      for (int r = 1; r < ROWS; r++) b_pin[r][c] = b_q[r-1][c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          acc[r][c] <= '0;
        end
      end
    end else if (adv) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c] <= a_pin[r][c];
          b_q[r][c] <= b_pin[r][c];
          acc[r][c] <= acc[r][c] + mul_ext(a_pin[r][c], b_pin[r][c]);
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (out_row == RW'(r)) begin
        for (int c = 0; c < COLS; c++) out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc[r][c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Bench for systolic_mac_array: a signed/32-bit and an unsigned/16-bit 3x4 array run in lockstep
// on shared stimulus, each checked against a matrix-product reference model.
`timescale 1ns/1ps
module tb_systolic_mac_array;
  localparam int R    = 3;
  localparam int C    = 4;
  localparam int DW   = 8;
  localparam int FL   = R + C - 2;
  localparam int MAXK = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid, in_last, out_ready;
  logic [R*DW-1:0] a_in;
  logic [C*DW-1:0] b_in;
  logic            in_ready_s, out_valid_s, busy_s;
  logic [C*32-1:0] out_data_s;
  logic [1:0]      out_row_s;
  logic            in_ready_u, out_valid_u, busy_u;
  logic [C*16-1:0] out_data_u;
  logic [1:0]      out_row_u;

  systolic_mac_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(32), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_row(out_row_s), .busy(busy_s));

  systolic_mac_array #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(16), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_data(out_data_u), .out_row(out_row_u), .busy(busy_u));

  int a_m [MAXK][R];
  int b_m [MAXK][C];
  logic [63:0] exp_s_q[$];
  logic [63:0] exp_u_q[$];
  int total = 0;
  int bad   = 0;

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ir, input logic ov, input logic bz);
    chk({tag, ".in_ready_s"},  64'(in_ready_s),  64'(ir));
    chk({tag, ".out_valid_s"}, 64'(out_valid_s), 64'(ov));
    chk({tag, ".busy_s"},      64'(busy_s),      64'(bz));
    chk({tag, ".in_ready_u"},  64'(in_ready_u),  64'(ir));
    chk({tag, ".out_valid_u"}, 64'(out_valid_u), 64'(ov));
    chk({tag, ".busy_u"},      64'(busy_u),      64'(bz));
  endtask

  // reference: C[r][c] = sum_k A[r][k]*B[k][c], reduced modulo 2^accw
  function automatic logic [63:0] model(input bit sgn, input int accw, input int r, input int c, input int kk);
    longint s = 0;
    longint av, bv;
    for (int k = 0; k < kk; k++) begin
      av = longint'(a_m[k][r]);
      bv = longint'(b_m[k][c]);
      if (sgn && av >= 128) av = av - 256;
      if (sgn && bv >= 128) bv = bv - 256;
      s = s + av * bv;
    end
    return 64'(s) & ((64'd1 << accw) - 64'd1);
  endfunction

  // mode 0 random, 1 = 2x2 example embedded in zeros, 2 = all 0x80, 3 = all 0xFF
  task automatic fill(input int mode, input int kk);
    int s1a [2][2];
    int s1b [2][2];
    s1a = '{'{1, 3}, '{2, 4}};
    s1b = '{'{5, 6}, '{7, 8}};
    for (int k = 0; k < kk; k++) begin
      for (int r = 0; r < R; r++) begin
        case (mode)
          0:       a_m[k][r] = int'($urandom_range(0, 255));
          1:       a_m[k][r] = (r < 2 && k < 2) ? s1a[k][r] : 0;
          2:       a_m[k][r] = 128;
          default: a_m[k][r] = 255;
        endcase
      end
      for (int c = 0; c < C; c++) begin
        case (mode)
          0:       b_m[k][c] = int'($urandom_range(0, 255));
          1:       b_m[k][c] = (c < 2 && k < 2) ? s1b[k][c] : 0;
          2:       b_m[k][c] = 128;
          default: b_m[k][c] = 255;
        endcase
      end
    end
  endtask

  task automatic drive_junk();
    a_in    = (R*DW)'($urandom);
    b_in    = (C*DW)'($urandom);
    in_last = 1'($urandom_range(0, 1));
  endtask

  // driver: one tile; gap<0 means random gaps; abort resets the array mid-flush
  task automatic run_tile(input int mode, input int kk, input int gap, input int stall,
                          input bit rbp, input bit abort);
    int  ngap;
    int  stall_left;
    int  nst;
    bit  taken;
    fill(mode, kk);
    for (int k = 0; k < kk; k++) begin
      if (k > 0) begin
        ngap = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int g = 0; g < ngap; g++) begin
          in_valid = 1'b0;
          drive_junk();
          chk_state("gap", 1'b1, 1'b0, 1'b0);
          step();
        end
      end
      in_valid = 1'b1;
      in_last  = (k == kk - 1);
      for (int r = 0; r < R; r++) a_in[r*DW +: DW] = 8'(a_m[k][r]);
      for (int c = 0; c < C; c++) b_in[c*DW +: DW] = 8'(b_m[k][c]);
      chk_state("beat", 1'b1, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < FL; i++) begin
      in_valid = 1'b1;
      drive_junk();
      in_last = 1'b1;
      if (abort && i == 2) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        chk_state("after_rst", 1'b1, 1'b0, 1'b0);
        chk("after_rst.out_row_s", 64'(out_row_s), 64'd0);
        chk("after_rst.out_row_u", 64'(out_row_u), 64'd0);
        return;
      end
      chk_state("flush", 1'b0, 1'b0, 1'b1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        exp_s_q.push_back(model(1'b1, 32, r, c, kk));
        exp_u_q.push_back(model(1'b0, 16, r, c, kk));
      end
    end
    stall_left = stall;
    for (int r = 0; r < R; r++) begin
      taken = 1'b0;
      nst   = 0;
      while (!taken) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else if (rbp && nst < 3 && $urandom_range(0, 2) == 0) begin
          out_ready = 1'b0;
          nst++;
        end else begin
          out_ready = 1'b1;
        end
        chk_state("drain", 1'b0, 1'b1, 1'b1);
        chk("drain.out_row_s", 64'(out_row_s), 64'(r));
        chk("drain.out_row_u", 64'(out_row_u), 64'(r));
        for (int c = 0; c < C; c++) begin
          chk($sformatf("s.r%0d.c%0d", r, c), 64'(out_data_s[c*32 +: 32]), exp_s_q[c]);
          chk($sformatf("u.r%0d.c%0d", r, c), 64'(out_data_u[c*16 +: 16]), exp_u_q[c]);
        end
        taken = out_ready;
        step();
      end
      for (int c = 0; c < C; c++) begin
        void'(exp_s_q.pop_front());
        void'(exp_u_q.pop_front());
      end
    end
    out_ready = 1'b0;
    chk_state("post_drain", 1'b1, 1'b0, 1'b0);
    chk("post_drain.out_row_s", 64'(out_row_s), 64'd0);
    chk("post_drain.out_row_u", 64'(out_row_u), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_state("reset", 1'b1, 1'b0, 1'b0);
    chk("reset.out_row_s", 64'(out_row_s), 64'd0);
    chk("reset.out_row_u", 64'(out_row_u), 64'd0);

    run_tile(1, 2, 0, 0, 1'b0, 1'b0);   // basic example
    run_tile(1, 2, 3, 0, 1'b0, 1'b0);   // input gaps
    run_tile(1, 2, 0, 5, 1'b0, 1'b0);   // output backpressure
    run_tile(0, 4, 0, 0, 1'b0, 1'b1);   // reset mid-flush
    run_tile(1, 2, 0, 0, 1'b0, 1'b0);   // clean tile after abort
    run_tile(2, 1, 0, 0, 1'b0, 1'b0);   // 0x80 operands
    run_tile(3, 1, 0, 0, 1'b0, 1'b0);   // 0xFF operands
    run_tile(3, 2, 0, 0, 1'b0, 1'b0);   // 16-bit wrap-around
    for (int t = 0; t < 20; t++) begin
      run_tile(0, int'($urandom_range(1, MAXK)), -1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
